// File: rtl/loop_sum_pkg.sv
// Shared types and constants for the loop_sum_core sum-loop engine.
package loop_sum_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_I = 3'd1,
    INIT_S = 3'd2,
    CHECK  = 3'd3,
    SUM    = 3'd4,
    INC    = 3'd5,
    OUT    = 3'd6,
    DONE   = 3'd7
  } state_t;

  localparam int unsigned R_ZERO = 0;
  localparam int unsigned R_I    = 1;
  localparam int unsigned R_SUM  = 2;

  typedef enum logic {
    B_RDATA2 = 1'b0,
    B_ONE    = 1'b1
  } bsel_t;

endpackage

// File: rtl/loop_sum_if.sv
// Host-side start/limit request and result/status bundle for loop_sum_core.
interface loop_sum_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] limit;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] out_port;
  logic              overflow;

  modport master (
    output start, limit,
    input  busy, done, out_port, overflow
  );

  modport slave (
    input  start, limit,
    output busy, done, out_port, overflow
  );
endinterface

// File: rtl/loop_sum_regfile.sv
// Two-read/one-write register file; address 0 is hardwired to zero.
module loop_sum_regfile #(
  parameter int DATA_W = 8,
  parameter int RF_AW  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RF_AW-1:0]  wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [RF_AW-1:0]  ra1,
  input  logic [RF_AW-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] mem [2**RF_AW];

  always_ff @(posedge clk) begin
    if (we && (wa != '0)) mem[wa] <= wd;
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/loop_sum_core.sv
// FSM-sequenced engine computing 1+2+...+limit through a regfile/adder datapath.
// Optional feature: define SATURATE_EN to clamp the accumulator at all-ones on carry.
module loop_sum_core
  import loop_sum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RF_AW  = 3
) (
  input logic       clk,
  input logic       reset,
  loop_sum_if.slave bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] limit_q, limit_d;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic              overflow_q, overflow_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              we;
  logic [RF_AW-1:0]  wa, ra1, ra2;
  logic [DATA_W-1:0] rd1, rd2, op_b, sum, wdata;
  logic [DATA_W:0]   add_full;
  logic              carry, le;
  bsel_t             bsel;

  loop_sum_regfile #(.DATA_W(DATA_W), .RF_AW(RF_AW)) u_rf (
    .clk (clk),
    .we  (we),
    .wa  (wa),
    .wd  (wdata),
    .ra1 (ra1),
    .ra2 (ra2),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // Init steps reuse the adder: R_ZERO + 1 seeds R_I, R_ZERO + R_ZERO clears R_SUM.
  always_comb begin
    we   = 1'b0;
    wa   = RF_AW'(R_ZERO);
    ra1  = RF_AW'(R_ZERO);
    ra2  = RF_AW'(R_ZERO);
    bsel = B_RDATA2;
    case (state_q)
      INIT_I: begin we = 1'b1; wa = RF_AW'(R_I); bsel = B_ONE; end
      INIT_S: begin we = 1'b1; wa = RF_AW'(R_SUM); end
      CHECK:  ra2 = RF_AW'(R_I);
      SUM: begin
        we  = 1'b1;
        wa  = RF_AW'(R_SUM);
        ra1 = RF_AW'(R_SUM);
        ra2 = RF_AW'(R_I);
      end
      INC: begin we = 1'b1; wa = RF_AW'(R_I); ra1 = RF_AW'(R_I); bsel = B_ONE; end
      OUT:    ra1 = RF_AW'(R_SUM);
      default: ;
    endcase
  end

  always_comb begin
    op_b     = (bsel == B_ONE) ? DATA_W'(1) : rd2;
    add_full = {1'b0, rd1} + {1'b0, op_b};
    carry    = add_full[DATA_W];
    sum      = add_full[DATA_W-1:0];
    le       = (rd2 <= limit_q);
`ifdef SATURATE_EN
    wdata = ((state_q == SUM) && (carry || overflow_q)) ? '1 : sum;
`else
    wdata = sum;
`endif
  end

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    out_port_d = out_port_q;
    overflow_d = overflow_q;
    wrap_d     = wrap_q;
    case (state_q)
      IDLE: if (bus.start) begin
        limit_d    = bus.limit;
        overflow_d = 1'b0;
        wrap_d     = 1'b0;
        state_d    = INIT_I;
      end
      INIT_I: state_d = INIT_S;
      INIT_S: state_d = CHECK;
      CHECK:  state_d = (le && !wrap_q) ? SUM : OUT;
      SUM: begin
        if (carry) overflow_d = 1'b1;
        state_d = INC;
      end
      INC: begin
        if (carry) wrap_d = 1'b1;
        state_d = CHECK;
      end
      OUT: begin
        out_port_d = rd1;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      out_port_q <= '0;
      overflow_q <= 1'b0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      out_port_q <= out_port_d;
      overflow_q <= overflow_d;
      wrap_q     <= wrap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.out_port = out_port_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_loop_sum_core.sv
// Directed self-checking bench for loop_sum_core at DATA_W=8 and DATA_W=16.
module tb_loop_sum_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  loop_sum_if #(.DATA_W(8))  b8 ();
  loop_sum_if #(.DATA_W(16)) b16 ();

  loop_sum_core #(.DATA_W(8), .RF_AW(3)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  loop_sum_core #(.DATA_W(16), .RF_AW(4)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one job on the chosen DUT (sel=1 -> 16-bit) and checks latency/result/flags.
  task automatic applyStimulus(input bit sel, input logic [15:0] n, input int exp_cyc,
                               input logic [31:0] exp_out, input logic exp_ovf, input string tag);
    int cyc;
    bit seen;
    @(negedge clk);
    if (sel) begin b16.start = 1'b1; b16.limit = n; end
    else begin b8.start = 1'b1; b8.limit = n[7:0]; end
    @(posedge clk); #1;
    b8.start = 1'b0;
    b16.start = 1'b0;
    checkOutput({tag, "_busy_rise"}, sel ? b16.busy : b8.busy, 1);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      seen = sel ? b16.done : b8.done;
    end
    checkOutput({tag, "_latency"}, cyc, exp_cyc);
    checkOutput({tag, "_out"}, sel ? {16'h0, b16.out_port} : {24'h0, b8.out_port}, exp_out);
    checkOutput({tag, "_ovf"}, sel ? b16.overflow : b8.overflow, exp_ovf);
    @(posedge clk); #1;
    checkOutput({tag, "_busy_fall"}, sel ? b16.busy : b8.busy, 0);
    checkOutput({tag, "_done_pulse"}, sel ? b16.done : b8.done, 0);
  endtask

  initial begin
    int pulses;
    b8.start = 1'b0;
    b8.limit = '0;
    b16.start = 1'b0;
    b16.limit = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", b8.busy, 0);
    checkOutput("rst_done", b8.done, 0);
    checkOutput("rst_out", b8.out_port, 0);
    checkOutput("rst_ovf", b8.overflow, 0);
    checkOutput("rst_out16", b16.out_port, 0);
    reset = 1'b0;

    applyStimulus(0, 16'd10, 34, 55, 0, "n10");
    applyStimulus(0, 16'd0, 4, 0, 0, "n0");
`ifdef SATURATE_EN
    applyStimulus(0, 16'd23, 73, 255, 1, "n23");
    applyStimulus(0, 16'd255, 769, 255, 1, "n255");
`else
    applyStimulus(0, 16'd23, 73, 20, 1, "n23");
    applyStimulus(0, 16'd255, 769, 128, 1, "n255");
`endif
    applyStimulus(0, 16'd10, 34, 55, 0, "ovf_clear");

    // Start limit=10, re-pulse start with limit=3 mid-run, then reset at cycle 20.
    @(negedge clk);
    b8.start = 1'b1;
    b8.limit = 8'd10;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    b8.start = 1'b1;
    b8.limit = 8'd3;
    pulses = 0;
    @(posedge clk); #1;
    b8.start = 1'b0;
    for (int c = 6; c <= 19; c++) begin
      @(posedge clk); #1;
      if (b8.done) pulses++;
    end
    checkOutput("ignored_start_no_done", pulses, 0);
    checkOutput("ignored_start_busy", b8.busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", b8.busy, 0);
    checkOutput("midrst_out", b8.out_port, 0);
    checkOutput("midrst_done", b8.done, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (b8.done) pulses++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (b8.done) pulses++;
    end
    checkOutput("midrst_no_done", pulses, 0);
    applyStimulus(0, 16'd3, 13, 6, 0, "n3_fresh");

    applyStimulus(1, 16'd300, 904, 45150, 0, "w16_n300");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
